lattice_result_collector: RTL and testbench

Sits at the output end of the lattice core chain and consumes the processor-results stream together with the valid and new-block strobes from the last lattice block. It rebuilds the full 32-bit nonce for every successful hash from a per-block round counter and the winning partition index. Found nonces are buffered in a small FIFO and drained by the host side through a valid/ready handshake. It also produces per-block status: hit count, overflow flag and nonce-space-exhausted pulse.

---
 rtl/lattice_pkg.sv | 8 +
 rtl/lattice_result_collector_if.sv | 7 +
 rtl/lattice_nonce_fifo.sv | 46 ++++
 rtl/lattice_result_collector.sv | 52 +++++
 tb/tb_lattice_result_collector.sv | 136 +++++++++++++
 5 files changed

// File: rtl/lattice_pkg.sv
// lattice_pkg: shared widths and types for the lattice result collector
package lattice_pkg;
  localparam int LOG2_CORES = 1;
  localparam int NONCE_BITS = 32;
  localparam int RW = NONCE_BITS - LOG2_CORES;
  typedef logic [NONCE_BITS-1:0] nonce_t;
  typedef logic [LOG2_CORES-1:0] partition_t;
endpackage

// File: rtl/lattice_result_collector_if.sv
// processorResultsIfc: success flag plus winning partition index from a lattice block
interface processorResultsIfc #(parameter int LOG2_NUM_CORES = 1);
  logic success;
  logic [LOG2_NUM_CORES-1:0] partition;
  modport writer (output success, output partition);
  modport reader (input success, input partition);
endinterface

// File: rtl/lattice_nonce_fifo.sv
// lattice_nonce_fifo: synchronous FIFO with wrap-bit pointers and a registered head
module lattice_nonce_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic [W-1:0] head_d;
  logic empty, do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d = wr_q + (AW+1)'(do_push);
  assign rd_d = rd_q + (AW+1)'(do_pop);
  // the new head is the incoming word when it lands in the slot being exposed
  assign head_d = (do_push && wr_q[AW-1:0] == rd_d[AW-1:0]) ? din_i : mem[rd_d[AW-1:0]];
  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din_i;
  end
  // pointers and registered head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      dout_o <= '0;
      valid_o <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      dout_o <= head_d;
      valid_o <= wr_d != rd_d;
    end
  end
endmodule

// File: rtl/lattice_result_collector.sv
// lattice_result_collector: rebuilds found nonces, buffers them and tracks per-block status
module lattice_result_collector
  import lattice_pkg::*;
#(
  parameter int LOG2_NUM_CORES = LOG2_CORES,
  parameter int NONCE_W = NONCE_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  processorResultsIfc.reader results_i,
  input  logic               valid_i,
  input  logic               new_block_i,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               nonce_valid_o,
  input  logic               nonce_ready_i,
  output logic [COUNT_W-1:0] hit_count_o,
  output logic               overflow_o,
  output logic               exhausted_o
);
  localparam int RWL = NONCE_W - LOG2_NUM_CORES;
  logic [RWL-1:0] round_q, eff;
  logic hit, full, drop;
  assign eff = new_block_i ? '0 : round_q;
  assign hit = valid_i && results_i.success;
  assign drop = hit && full && !(nonce_valid_o && nonce_ready_i);
  lattice_nonce_fifo #(.W(NONCE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(hit),
    .din_i({eff, results_i.partition}),
    .pop_i(nonce_ready_i),
    .dout_o(nonce_o),
    .valid_o(nonce_valid_o),
    .full_o(full)
  );
  // round counter, exhaustion pulse, saturating hit count and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_q <= '0;
      exhausted_o <= 1'b0;
      hit_count_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      round_q <= valid_i ? eff + RWL'(1) : (new_block_i ? '0 : round_q);
      exhausted_o <= valid_i && (eff == '1);
      hit_count_o <= new_block_i ? COUNT_W'(hit) : (hit && hit_count_o != '1) ? hit_count_o + COUNT_W'(1) : hit_count_o;
      overflow_o <= new_block_i ? drop : (overflow_o | drop);
    end
  end
endmodule

// File: tb/tb_lattice_result_collector.sv
// tb_lattice_result_collector: table-driven check of nonce rebuild, FIFO, status and reset
module tb_lattice_result_collector;
  import lattice_pkg::*;
  typedef struct {
    logic v, nb, s, p, r;
    logic ev;
    logic [31:0] en;
    logic [7:0] eh;
    logic eo;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 0, nb = 0, rdy = 0;
  logic v2 = 0, nb2 = 0, rdy2 = 0;
  logic [31:0] nonce;
  logic nvalid, ovf, exh;
  logic [7:0] hits;
  logic [3:0] nonce2;
  logic nvalid2, ovf2, exh2;
  logic [7:0] hits2;
  int checks = 0;
  int errors = 0;
  vec_t tbl [26];
  processorResultsIfc #(.LOG2_NUM_CORES(1)) res_if ();
  processorResultsIfc #(.LOG2_NUM_CORES(1)) res2_if ();
  always #5 clk = ~clk;
  lattice_result_collector #(.LOG2_NUM_CORES(1), .NONCE_W(32), .FIFO_DEPTH(4), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .results_i(res_if.reader), .valid_i(v), .new_block_i(nb),
    .nonce_o(nonce), .nonce_valid_o(nvalid), .nonce_ready_i(rdy),
    .hit_count_o(hits), .overflow_o(ovf), .exhausted_o(exh)
  );
  lattice_result_collector #(.LOG2_NUM_CORES(1), .NONCE_W(4), .FIFO_DEPTH(4), .COUNT_W(8)) dut_small (
    .clk(clk), .rst(rst), .results_i(res2_if.reader), .valid_i(v2), .new_block_i(nb2),
    .nonce_o(nonce2), .nonce_valid_o(nvalid2), .nonce_ready_i(rdy2),
    .hit_count_o(hits2), .overflow_o(ovf2), .exhausted_o(exh2)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(logic iv, logic inb, logic is, logic ip, logic ir,
                              logic ev, logic [31:0] en, logic [7:0] eh, logic eo);
    vec_t t;
    t.v = iv; t.nb = inb; t.s = is; t.p = ip; t.r = ir;
    t.ev = ev; t.en = en; t.eh = eh; t.eo = eo;
    return t;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    res_if.success = 0; res_if.partition = 0;
    res2_if.success = 0; res2_if.partition = 0;
    tbl[0]  = mk(1,1,0,0,0, 0,  0, 0, 0);
    tbl[1]  = mk(1,0,0,0,0, 0,  0, 0, 0);
    tbl[2]  = mk(1,0,1,1,0, 1,  5, 1, 0);
    tbl[3]  = mk(1,0,1,0,0, 1,  5, 2, 0);
    tbl[4]  = mk(1,0,1,1,0, 1,  5, 3, 0);
    tbl[5]  = mk(1,0,1,0,0, 1,  5, 4, 0);
    tbl[6]  = mk(1,0,1,1,0, 1,  5, 5, 1);
    tbl[7]  = mk(0,0,0,0,1, 1,  6, 5, 1);
    tbl[8]  = mk(0,0,0,0,1, 1,  9, 5, 1);
    tbl[9]  = mk(0,0,0,0,1, 1, 10, 5, 1);
    tbl[10] = mk(0,0,0,0,1, 0,  0, 5, 1);
    tbl[11] = mk(1,1,1,0,0, 1,  0, 1, 0);
    tbl[12] = mk(1,0,1,1,0, 1,  0, 2, 0);
    tbl[13] = mk(1,0,1,0,0, 1,  0, 3, 0);
    tbl[14] = mk(1,0,1,1,0, 1,  0, 4, 0);
    tbl[15] = mk(1,0,1,0,1, 1,  3, 5, 0);
    tbl[16] = mk(0,0,1,0,0, 1,  3, 5, 0);
    tbl[17] = mk(1,0,1,1,0, 1,  3, 6, 1);
    tbl[18] = mk(0,0,0,0,1, 1,  4, 6, 1);
    tbl[19] = mk(0,0,0,0,1, 1,  7, 6, 1);
    tbl[20] = mk(1,1,1,0,0, 1,  7, 1, 0);
    tbl[21] = mk(0,0,0,0,1, 1,  8, 1, 0);
    tbl[22] = mk(0,0,0,0,1, 1,  0, 1, 0);
    tbl[23] = mk(0,0,0,0,1, 0,  0, 1, 0);
    tbl[24] = mk(0,1,0,0,0, 0,  0, 0, 0);
    tbl[25] = mk(1,0,1,1,0, 1,  1, 1, 0);
    #1 rst = 0;
    #2;
    chk("reset nonce", nonce, 0);
    chk("reset valid", 32'(nvalid), 0);
    chk("reset hits", 32'(hits), 0);
    chk("reset overflow", 32'(ovf), 0);
    chk("reset exhausted", 32'(exh), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    for (int i = 0; i < 26; i++) begin
      v = tbl[i].v; nb = tbl[i].nb; rdy = tbl[i].r;
      res_if.success = tbl[i].s; res_if.partition = tbl[i].p;
      step();
      chk($sformatf("row%0d valid", i), 32'(nvalid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d nonce", i), nonce, tbl[i].en);
      chk($sformatf("row%0d hits", i), 32'(hits), 32'(tbl[i].eh));
      chk($sformatf("row%0d overflow", i), 32'(ovf), 32'(tbl[i].eo));
    end
    v = 0; nb = 0; rdy = 0; res_if.success = 0;
    #2 rst = 0;
    #1;
    chk("async nonce", nonce, 0);
    chk("async valid", 32'(nvalid), 0);
    chk("async hits", 32'(hits), 0);
    chk("async overflow", 32'(ovf), 0);
    chk("async exhausted", 32'(exh), 0);
    @(posedge clk);
    #1 rst = 1;
    v = 1; nb = 1; rdy = 1; res_if.success = 1; res_if.partition = 0;
    step();
    nb = 0;
    repeat (299) step();
    chk("saturated hits", 32'(hits), 255);
    chk("saturated overflow", 32'(ovf), 0);
    v = 0; res_if.success = 0; rdy = 0;
    v2 = 1; nb2 = 1;
    step();
    chk("exh after round 0", 32'(exh2), 0);
    nb2 = 0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("exh after round %0d", k), 32'(exh2), (k == 7) ? 1 : 0);
    end
    res2_if.success = 1; res2_if.partition = 1;
    step();
    chk("exh pulse end", 32'(exh2), 0);
    chk("wrap nonce valid", 32'(nvalid2), 1);
    chk("wrap nonce", 32'(nonce2), 1);
    v2 = 0; res2_if.success = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
